mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the instruction-fetch requester (IF, port 0)
//  and the load/store requester (DM, port 1) of the multicycle core. Holds one

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/arb_rr2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM state encodings and requester port IDs.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_t;

   localparam int unsigned PORT_NUM = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory handshake bundle for the arbiter; slave is the arbiter side,
// master is the surrounding fetch/mem stages plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;

   logic              dm_req_valid;
   logic              dm_req_ready;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [STRB_W-1:0] dm_wstrb;
   logic              dm_rsp_valid;
   logic [DATA_W-1:0] dm_rsp_data;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;

   modport slave (
      input  if_req_valid, if_addr,
      input  dm_req_valid, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output dm_req_ready, dm_rsp_valid, dm_rsp_data,
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req_valid, if_addr,
      output dm_req_valid, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port that was not
// served last. Grant is one-hot or zero.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last == PORT_IF) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (DM),
// one transaction in flight, responses routed back to the issuing port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and accept one request
// ST_ISSUE | latched request presented on mem_req_*, waiting for mem_req_ready
// ST_WAIT  | request accepted by memory, waiting for mem_rsp_valid or timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              err
);

   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

   state_t            state_q, state_d;
   port_t             owner_q, owner_d;
   port_t             last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [31:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]        rsp_pulse_q, rsp_pulse_d;
   logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d;
   logic [DATA_W-1:0] dm_rsp_data_q, dm_rsp_data_d;
   logic              err_q, err_d;

   logic [1:0]        grant;
   logic              rsp_fire;
   logic [DATA_W-1:0] rsp_word;

   arb_rr2 u_arb (
      .req   ({bus.dm_req_valid, bus.if_req_valid}),
      .last  (last_grant_q),
      .grant (grant)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      wait_cnt_d    = wait_cnt_q;
      rsp_pulse_d   = 2'b00;
      if_rsp_data_d = if_rsp_data_q;
      dm_rsp_data_d = dm_rsp_data_q;
      err_d         = err_q;
      rsp_fire      = 1'b0;
      rsp_word      = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant[1]) begin
               owner_d = PORT_DM;
               we_d    = bus.dm_we;
               addr_d  = bus.dm_addr;
               wdata_d = bus.dm_wdata;
               wstrb_d = bus.dm_we ? bus.dm_wstrb : '0;
               state_d = ST_ISSUE;
            end else if (grant[0]) begin
               owner_d = PORT_IF;
               we_d    = 1'b0;
               addr_d  = bus.if_addr;
               wdata_d = '0;
               wstrb_d = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.mem_req_ready) begin
               wait_cnt_d = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + 32'd1;
            // A response landing on the timeout cycle still counts as a normal completion.
            if (bus.mem_rsp_valid) begin
               rsp_fire = 1'b1;
               rsp_word = we_q ? '0 : bus.mem_rsp_data;
            end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
               rsp_fire = 1'b1;
               rsp_word = '0;
               err_d    = 1'b1;
            end
            if (rsp_fire) begin
               last_grant_d = owner_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.mem_rsp_valid && (state_q != ST_WAIT)) begin
         err_d = 1'b1;
      end

      if (rsp_fire) begin
         if (owner_q == PORT_DM) begin
            dm_rsp_data_d = rsp_word;
            rsp_pulse_d   = 2'b10;
         end else begin
            if_rsp_data_d = rsp_word;
            rsp_pulse_d   = 2'b01;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= PORT_IF;
         last_grant_q  <= PORT_IF;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         wait_cnt_q    <= '0;
         rsp_pulse_q   <= 2'b00;
         if_rsp_data_q <= '0;
         dm_rsp_data_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         wait_cnt_q    <= wait_cnt_d;
         rsp_pulse_q   <= rsp_pulse_d;
         if_rsp_data_q <= if_rsp_data_d;
         dm_rsp_data_q <= dm_rsp_data_d;
         err_q         <= err_d;
      end
   end

   // Ready is only offered in IDLE, so a request dropped before then leaves no trace.
   assign bus.if_req_ready  = (state_q == ST_IDLE) && grant[0];
   assign bus.dm_req_ready  = (state_q == ST_IDLE) && grant[1];
   assign bus.if_rsp_valid  = rsp_pulse_q[0];
   assign bus.dm_rsp_valid  = rsp_pulse_q[1];
   assign bus.if_rsp_data   = if_rsp_data_q;
   assign bus.dm_rsp_data   = dm_rsp_data_q;

   assign bus.mem_req_valid = (state_q == ST_ISSUE);
   assign bus.mem_we        = we_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wstrb     = wstrb_q;

   assign busy = (state_q != ST_IDLE);
   assign err  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT_CYC=4) with a small behavioural memory.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic rst;
   logic busy;
   logic err;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .err  (err)
   );

   logic [1:0] arb_req;
   port_t      arb_last;
   logic [1:0] arb_grant;

   arb_rr2 u_arb_chk (
      .req   (arb_req),
      .last  (arb_last),
      .grant (arb_grant)
   );

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model controls, each written only by the main sequence
   bit no_rsp     = 1'b0;
   int rsp_lat    = 1;
   int stall_n    = 0;
   int spur_req   = 0;

   int if_pulses = 0;
   int dm_pulses = 0;

   always @(negedge clk) begin
      if (bus.if_rsp_valid) if_pulses <= if_pulses + 1;
      if (bus.dm_rsp_valid) dm_pulses <= dm_pulses + 1;
   end

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
      return (a ^ 32'h5A5A_0000) | 32'h1;
   endfunction

   // behavioural memory: stalls ready stall_n cycles, responds rsp_lat cycles after accept
   initial begin : memory
      bit          pend;
      int          p_cnt;
      int          stall_cnt;
      int          spur_done;
      logic [31:0] p_addr;
      pend = 1'b0; p_cnt = 0; stall_cnt = 0; spur_done = 0; p_addr = '0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
            stall_cnt = 0;
         end else if (bus.mem_req_valid && bus.mem_req_ready) begin
            pend = 1'b1;
            p_cnt = rsp_lat;
            p_addr = bus.mem_addr;
            stall_cnt = 0;
         end
         @(posedge clk); #1;
         bus.mem_rsp_valid = 1'b0;
         if (spur_req != spur_done) begin
            spur_done = spur_req;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data = 32'h1234_5678;
         end else if (pend) begin
            p_cnt--;
            if (p_cnt <= 0) begin
               pend = 1'b0;
               if (!no_rsp) begin
                  bus.mem_rsp_valid = 1'b1;
                  bus.mem_rsp_data = mem_model(p_addr);
               end
            end
         end
         if (bus.mem_req_valid && (stall_cnt < stall_n)) begin
            bus.mem_req_ready = 1'b0;
            stall_cnt++;
         end else begin
            bus.mem_req_ready = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_reqs();
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
   endtask

   // full transaction on one port with bounded waits for grant and response
   task automatic xact(input bit dm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (dm) begin
            bus.dm_req_valid = 1'b1; bus.dm_we = we; bus.dm_addr = addr;
            bus.dm_wdata = wdata; bus.dm_wstrb = wstrb;
         end else begin
            bus.if_req_valid = 1'b1; bus.if_addr = addr;
         end
         #1;
         if (dm ? bus.dm_req_ready : bus.if_req_ready) got = 1'b1;
      end
      chk({tag, " grant"}, 32'(got), 32'd1);
      step(); clear_reqs(); #1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (dm ? bus.dm_rsp_valid : bus.if_rsp_valid) begin
            got = 1'b1;
            chk({tag, " data"}, dm ? bus.dm_rsp_data : bus.if_rsp_data, exp);
         end else begin
            step(); #1;
         end
      end
      chk({tag, " rsp"}, 32'(got), 32'd1);
   endtask

   initial begin : main
      int          g_n, r_n, last_g, snap_if, snap_dm;
      bit          exp_dm;
      logic [31:0] ia, da, exp_if_d, exp_dm_d;
      logic [1:0]  e;

      rst = 1'b1;
      clear_reqs();
      bus.if_addr = '0; bus.dm_we = 1'b0; bus.dm_addr = '0;
      bus.dm_wdata = '0; bus.dm_wstrb = '0;

      // round-robin picker, all eight input combinations
      for (int i = 0; i < 8; i++) begin
         arb_req  = 2'(i & 3);
         arb_last = (i >= 4) ? PORT_DM : PORT_IF;
         #1;
         if (arb_req == 2'b11) e = (arb_last == PORT_IF) ? 2'b10 : 2'b01;
         else e = arb_req;
         chk($sformatf("arb req=%b last=%0d", arb_req, i / 4), 32'(arb_grant), 32'(e));
      end

      // reset state
      step(); #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst if_req_ready", 32'(bus.if_req_ready), 32'd0);
      chk("rst dm_req_ready", 32'(bus.dm_req_ready), 32'd0);
      chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("rst dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      chk("rst if_rsp_data", bus.if_rsp_data, 32'd0);
      rst = 1'b0;

      // test 2: both held from the first cycle after reset, strict DM/IF alternation
      g_n = 0; r_n = 0; last_g = 0; exp_dm = 1'b1;
      ia = 32'h0000_0100; da = 32'h0000_0200; exp_if_d = '0; exp_dm_d = '0;
      for (int c = 0; c < 100 && r_n < 8; c++) begin
         step();
         bus.if_req_valid = (g_n < 8);
         bus.dm_req_valid = (g_n < 8);
         bus.dm_we = 1'b0;
         bus.if_addr = ia;
         bus.dm_addr = da;
         #1;
         if (bus.if_rsp_valid) begin
            chk("t2 if data", bus.if_rsp_data, exp_if_d);
            r_n++;
         end
         if (bus.dm_rsp_valid) begin
            chk("t2 dm data", bus.dm_rsp_data, exp_dm_d);
            r_n++;
         end
         if (bus.if_req_ready || bus.dm_req_ready) begin
            chk("t2 onehot ready", 32'(bus.if_req_ready & bus.dm_req_ready), 32'd0);
            chk($sformatf("t2 grant %0d is dm", g_n), 32'(bus.dm_req_ready), 32'(exp_dm));
            if (g_n > 0) chk("t2 grant spacing", 32'(c - last_g), 32'd3);
            last_g = c;
            g_n++;
            if (bus.dm_req_ready) begin exp_dm_d = mem_model(da); da += 32'd4; end
            else begin exp_if_d = mem_model(ia); ia += 32'd4; end
            exp_dm = !exp_dm;
         end
      end
      clear_reqs();
      chk("t2 grants", 32'(g_n), 32'd8);
      chk("t2 responses", 32'(r_n), 32'd8);

      // test 1: single IF read of 0x10, response two cycles after accept
      snap_dm = dm_pulses;
      step(); bus.if_req_valid = 1'b1; bus.if_addr = 32'h10; #1;
      chk("t1 if_req_ready", 32'(bus.if_req_ready), 32'd1);
      chk("t1 dm_req_ready", 32'(bus.dm_req_ready), 32'd0);
      step(); bus.if_req_valid = 1'b0; bus.if_addr = 32'hFFFF_FFF0; #1;
      chk("t1 mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("t1 mem_addr", bus.mem_addr, 32'h10);
      chk("t1 mem_we", 32'(bus.mem_we), 32'd0);
      chk("t1 mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("t1 busy", 32'(busy), 32'd1);
      step(); #1;
      chk("t1 early rsp", 32'(bus.if_rsp_valid), 32'd0);
      step(); #1;
      chk("t1 if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
      chk("t1 if_rsp_data", bus.if_rsp_data, 32'hDEAD_BEEF);
      chk("t1 idle at rsp", 32'(busy), 32'd0);
      step(); #1;
      chk("t1 pulse width", 32'(bus.if_rsp_valid), 32'd0);
      chk("t1 data hold", bus.if_rsp_data, 32'hDEAD_BEEF);
      chk("t1 no dm pulse", 32'(dm_pulses - snap_dm), 32'd0);

      // test 3: DM write with memory stalling ready for 3 cycles
      stall_n = 3;
      step();
      bus.dm_req_valid = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h20;
      bus.dm_wdata = 32'h0000_00AB; bus.dm_wstrb = 4'b0001;
      #1;
      chk("t3 dm_req_ready", 32'(bus.dm_req_ready), 32'd1);
      step();
      bus.dm_req_valid = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '1; bus.dm_wstrb = 4'hF;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin step(); #1; end
         chk($sformatf("t3 c%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'd1);
         chk($sformatf("t3 c%0d mem_we", i), 32'(bus.mem_we), 32'd1);
         chk($sformatf("t3 c%0d mem_addr", i), bus.mem_addr, 32'h20);
         chk($sformatf("t3 c%0d mem_wdata", i), bus.mem_wdata, 32'h0000_00AB);
         chk($sformatf("t3 c%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'd1);
      end
      stall_n = 0;
      step(); #1;
      chk("t3 early rsp", 32'(bus.dm_rsp_valid), 32'd0);
      step(); #1;
      chk("t3 dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd1);
      chk("t3 dm_rsp_data", bus.dm_rsp_data, 32'd0);
      bus.dm_we = 1'b0;

      // test 4: memory never responds, timeout after 4 WAIT cycles
      no_rsp = 1'b1;
      step(); bus.if_req_valid = 1'b1; bus.if_addr = 32'h40; #1;
      chk("t4 if_req_ready", 32'(bus.if_req_ready), 32'd1);
      step(); bus.if_req_valid = 1'b0; #1;
      step(); step(); step(); step(); #1;
      chk("t4 still busy", 32'(busy), 32'd1);
      chk("t4 no early rsp", 32'(bus.if_rsp_valid), 32'd0);
      chk("t4 err before", 32'(err), 32'd0);
      step(); #1;
      chk("t4 timeout rsp", 32'(bus.if_rsp_valid), 32'd1);
      chk("t4 timeout data", bus.if_rsp_data, 32'd0);
      chk("t4 err set", 32'(err), 32'd1);
      chk("t4 idle", 32'(busy), 32'd0);
      no_rsp = 1'b0;
      xact(1'b1, 1'b0, 32'h44, '0, 4'h0, mem_model(32'h44), "t4 next dm read");
      chk("t4 err sticky", 32'(err), 32'd1);

      step(); rst = 1'b1; #1;
      step(); rst = 1'b0; #1;
      chk("rst clears err", 32'(err), 32'd0);

      // test 5: spurious response while idle
      spur_req++;
      step(); #1;
      snap_if = if_pulses; snap_dm = dm_pulses;
      chk("t5 err not yet", 32'(err), 32'd0);
      step(); #1;
      chk("t5 err set", 32'(err), 32'd1);
      step(); #1;
      chk("t5 no pulses", 32'((if_pulses - snap_if) + (dm_pulses - snap_dm)), 32'd0);
      xact(1'b0, 1'b0, 32'h30, '0, 4'h0, mem_model(32'h30), "t5 if read");
      chk("t5 err sticky", 32'(err), 32'd1);

      // test 6: reset while in WAIT
      rsp_lat = 3;
      step(); bus.if_req_valid = 1'b1; bus.if_addr = 32'h50; #1;
      chk("t6 if_req_ready", 32'(bus.if_req_ready), 32'd1);
      step(); bus.if_req_valid = 1'b0; #1;
      step(); rst = 1'b1; #1;
      chk("t6 busy in wait", 32'(busy), 32'd1);
      step(); rst = 1'b0; #1;
      snap_if = if_pulses; snap_dm = dm_pulses;
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 err", 32'(err), 32'd0);
      chk("t6 mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("t6 if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("t6 dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
      chk("t6 mem_addr", bus.mem_addr, 32'd0);
      chk("t6 if_rsp_data", bus.if_rsp_data, 32'd0);
      chk("t6 dm_rsp_data", bus.dm_rsp_data, 32'd0);
      step(); step(); step(); #1;
      chk("t6 no pulses", 32'((if_pulses - snap_if) + (dm_pulses - snap_dm)), 32'd0);
      rsp_lat = 1;
      xact(1'b0, 1'b0, 32'h60, '0, 4'h0, mem_model(32'h60), "t6 read after rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
